uart_load_ctrl: RTL and testbench

Frame-level controller that sequences the byte stream from the UART receiver into the processor's on-chip data memory. It parses a framed load command (sync, address, length, payload, checksum), generates memory write strobes, and supervises the transfer with an inter-byte timeout. It reports completion or error to the top-level processor control.

---
 rtl/uart_load_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_uart_load_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_load_ctrl.sv
// rtl/uart_load_ctrl.sv - UART frame loader: sync/address/length/payload/checksum into data memory
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   load_en    arms frame detection in IDLE; a frame already started ignores it
//   rx_valid   one-cycle byte strobe from the UART receiver
//   rx_data    received byte, qualified by rx_valid
//   mem_we     memory write strobe, one cycle per payload byte
//   mem_addr   memory write address (wraps modulo 2^ADDR_W)
//   mem_wdata  memory write data
//   busy       high whenever a frame is in progress
//   done       one-cycle pulse: frame finished with matching checksum
//   err        one-cycle pulse: checksum mismatch or inter-byte timeout
//   err_code   cause of the last err pulse (1=checksum, 2=timeout)

module uart_load_ctrl #(
    parameter int         ADDR_W      = 16,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_H,
        ADDR_L,
        LEN_H,
        LEN_L,
        DATA,
        CHK
    } stateType;

    stateType          state;
    stateType          stateNext;

    logic [7:0]        addrHi;
    logic [ADDR_W-1:0] baseAddr;
    logic [7:0]        lenHi;
    logic [15:0]       length;
    logic [15:0]       index;
    logic [7:0]        checksum;
    logic [CNT_W-1:0]  gapCnt;

    logic              syncHit;
    logic              lastByte;
    logic              timeoutHit;

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        stateNext  = state;
        syncHit    = rx_valid && load_en && (rx_data == SYNC_BYTE);
        lastByte   = ((index + 16'd1) == length);
        // A byte arriving on the expiry cycle takes priority, so the
        // timeout only fires on a cycle without rx_valid.
        timeoutHit = (state != IDLE) && !rx_valid &&
                     (gapCnt == CNT_W'(TIMEOUT_CYC - 1));

        case (state)
            IDLE: begin
                if (syncHit) begin
                    stateNext = ADDR_H;
                end
            end
            ADDR_H: begin
                if (rx_valid) begin
                    stateNext = ADDR_L;
                end
            end
            ADDR_L: begin
                if (rx_valid) begin
                    stateNext = LEN_H;
                end
            end
            LEN_H: begin
                if (rx_valid) begin
                    stateNext = LEN_L;
                end
            end
            LEN_L: begin
                if (rx_valid) begin
                    stateNext = ({lenHi, rx_data} == 16'd0) ? CHK : DATA;
                end
            end
            DATA: begin
                if (rx_valid && lastByte) begin
                    stateNext = CHK;
                end
            end
            CHK: begin
                if (rx_valid) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (timeoutHit) begin
            stateNext = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: header capture, memory writes, checksum, status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            addrHi    <= 8'd0;
            baseAddr  <= '0;
            lenHi     <= 8'd0;
            length    <= 16'd0;
            index     <= 16'd0;
            checksum  <= 8'd0;
            gapCnt    <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;

            // Inter-byte gap counter: idle in IDLE, restarted by every byte.
            if (state == IDLE || rx_valid || timeoutHit) begin
                gapCnt <= '0;
            end else begin
                gapCnt <= gapCnt + CNT_W'(1);
            end

            if (rx_valid) begin
                case (state)
                    IDLE: begin
                        if (syncHit) begin
                            checksum <= 8'd0;
                            index    <= 16'd0;
                        end
                    end
                    ADDR_H: begin
                        addrHi <= rx_data;
                    end
                    ADDR_L: begin
                        // Concatenation is 16 bits; the cast drops the upper
                        // bits for narrow memories.
                        baseAddr <= ADDR_W'({addrHi, rx_data});
                    end
                    LEN_H: begin
                        lenHi <= rx_data;
                    end
                    LEN_L: begin
                        length <= {lenHi, rx_data};
                        index  <= 16'd0;
                    end
                    DATA: begin
                        mem_we    <= 1'b1;
                        mem_wdata <= rx_data;
                        mem_addr  <= baseAddr + ADDR_W'(index);
                        checksum  <= checksum + rx_data;
                        index     <= index + 16'd1;
                    end
                    CHK: begin
                        if (rx_data == checksum) begin
                            done <= 1'b1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            if (timeoutHit) begin
                err      <= 1'b1;
                err_code <= 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_uart_load_ctrl.sv
// tb/tb_uart_load_ctrl.sv - directed vector bench for uart_load_ctrl (16-bit and 8-bit address builds)

module tb_uart_load_ctrl;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic        rx_valid;
    logic [7:0]  rx_data;

    logic        we16, busy16, done16, err16;
    logic [15:0] addr16;
    logic [7:0]  wd16;
    logic [1:0]  ec16;

    logic        we8, busy8, done8, err8;
    logic [7:0]  addr8;
    logic [7:0]  wd8;
    logic [1:0]  ec8;

    int nChecks = 0;
    int nFails  = 0;

    uart_load_ctrl #(.ADDR_W(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(20)) dut16 (
        .clk(clk), .rst(rst), .load_en(load_en), .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_we(we16), .mem_addr(addr16), .mem_wdata(wd16),
        .busy(busy16), .done(done16), .err(err16), .err_code(ec16)
    );

    uart_load_ctrl #(.ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(20)) dut8 (
        .clk(clk), .rst(rst), .load_en(load_en), .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_we(we8), .mem_addr(addr8), .mem_wdata(wd8),
        .busy(busy8), .done(done8), .err(err8), .err_code(ec8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        rst;
        logic        le;
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic        busy;
        logic        done;
        logic        err;
        logic [1:0]  ec;
    } vecType;

    vecType     vecs[$];
    logic [1:0] curEc;
    logic       curLe;

    task automatic push(input logic r, input logic le, input logic v, input logic [7:0] d,
                        input logic we, input logic [15:0] a, input logic [7:0] wd,
                        input logic bsy, input logic dn, input logic er, input logic [1:0] ec);
        vecType t;
        t.rst = r; t.le = le; t.v = v; t.d = d;
        t.we = we; t.addr = a; t.wd = wd;
        t.busy = bsy; t.done = dn; t.err = er; t.ec = ec;
        vecs.push_back(t);
    endtask

    task automatic hdr(input logic [7:0] d, input logic bsy);
        push(1'b0, curLe, 1'b1, d, 1'b0, 16'h0, 8'h0, bsy, 1'b0, 1'b0, curEc);
    endtask

    task automatic wr(input logic [7:0] d, input logic [15:0] a);
        push(1'b0, curLe, 1'b1, d, 1'b1, a, d, 1'b1, 1'b0, 1'b0, curEc);
    endtask

    task automatic idleRec(input logic bsy);
        push(1'b0, curLe, 1'b0, 8'h00, 1'b0, 16'h0, 8'h0, bsy, 1'b0, 1'b0, curEc);
    endtask

    task automatic chkOk(input logic [7:0] d);
        push(1'b0, curLe, 1'b1, d, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0, curEc);
    endtask

    task automatic chkBad(input logic [7:0] d);
        curEc = 2'd1;
        push(1'b0, curLe, 1'b1, d, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1, curEc);
    endtask

    task automatic rstRec();
        curEc = 2'd0;
        push(1'b1, curLe, 1'b0, 8'h00, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic frameA(input logic [7:0] chkByte, input logic good);
        hdr(8'hA5, 1'b1); hdr(8'h01, 1'b1); hdr(8'h00, 1'b1);
        hdr(8'h00, 1'b1); hdr(8'h03, 1'b1);
        wr(8'h11, 16'h0100); wr(8'h22, 16'h0101); wr(8'h33, 16'h0102);
        if (good) chkOk(chkByte);
        else      chkBad(chkByte);
        idleRec(1'b0);
    endtask

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ok;
        int   errAt;
        logic sawErr;

        rst      = 1'b1;
        load_en  = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        curEc    = 2'd0;
        curLe    = 1'b1;

        // ---------------- vector table ----------------
        rstRec();
        idleRec(1'b0);
        // good frame, then same frame with bad checksum
        frameA(8'h66, 1'b1);
        frameA(8'h67, 1'b0);
        // stray bytes then a zero-length frame
        hdr(8'h00, 1'b0); hdr(8'hFF, 1'b0);
        hdr(8'hA5, 1'b1); hdr(8'h00, 1'b1); hdr(8'h10, 1'b1);
        hdr(8'h00, 1'b1); hdr(8'h00, 1'b1);
        chkOk(8'h00);
        idleRec(1'b0);
        // address wrap: 0x00FE.. (16-bit build reaches 0x0100, 8-bit wraps to 0x00)
        hdr(8'hA5, 1'b1); hdr(8'h00, 1'b1); hdr(8'hFE, 1'b1);
        hdr(8'h00, 1'b1); hdr(8'h03, 1'b1);
        wr(8'h01, 16'h00FE); wr(8'h02, 16'h00FF); wr(8'h03, 16'h0100);
        chkOk(8'h06);
        idleRec(1'b0);
        // load_en drops right after the sync byte: frame still completes
        hdr(8'hA5, 1'b1);
        curLe = 1'b0;
        hdr(8'h02, 1'b1); hdr(8'h00, 1'b1); hdr(8'h00, 1'b1); hdr(8'h01, 1'b1);
        wr(8'h7F, 16'h0200);
        chkOk(8'h7F);
        idleRec(1'b0);
        // load_en low: sync byte ignored
        hdr(8'hA5, 1'b0); hdr(8'h01, 1'b0); idleRec(1'b0);
        curLe = 1'b1;
        // reset after the second payload byte, then a clean frame
        hdr(8'hA5, 1'b1); hdr(8'h03, 1'b1); hdr(8'h00, 1'b1);
        hdr(8'h00, 1'b1); hdr(8'h04, 1'b1);
        wr(8'h11, 16'h0300); wr(8'h22, 16'h0301);
        rstRec();
        idleRec(1'b0);
        frameA(8'h66, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst      = vecs[i].rst;
            load_en  = vecs[i].le;
            rx_valid = vecs[i].v;
            rx_data  = vecs[i].d;
            @(posedge clk);
            #1;
            ok = (we16 === vecs[i].we) && (we8 === vecs[i].we) &&
                 (busy16 === vecs[i].busy) && (busy8 === vecs[i].busy) &&
                 (done16 === vecs[i].done) && (done8 === vecs[i].done) &&
                 (err16 === vecs[i].err) && (err8 === vecs[i].err) &&
                 (ec16 === vecs[i].ec) && (ec8 === vecs[i].ec);
            if (vecs[i].we || vecs[i].rst) begin
                ok = ok && (addr16 === vecs[i].addr) && (addr8 === vecs[i].addr[7:0]) &&
                     (wd16 === vecs[i].wd) && (wd8 === vecs[i].wd);
            end
            nChecks++;
            if (!ok) begin
                nFails++;
                $display("FAIL vec[%0d]: got we=%b/%b addr=%h/%h wd=%h/%h busy=%b/%b done=%b/%b err=%b/%b ec=%0d/%0d; want we=%b addr=%h wd=%h busy=%b done=%b err=%b ec=%0d",
                         i, we16, we8, addr16, addr8, wd16, wd8, busy16, busy8, done16, done8,
                         err16, err8, ec16, ec8, vecs[i].we, vecs[i].addr, vecs[i].wd,
                         vecs[i].busy, vecs[i].done, vecs[i].err, vecs[i].ec);
            end
        end

        @(negedge clk);
        rst      = 1'b0;
        load_en  = 1'b1;
        rx_valid = 1'b0;

        // ---------------- timeout after 20 silent cycles ----------------
        step(1'b1, 8'hA5);
        step(1'b1, 8'h12);
        checkVal("to_busy_after_hdr", {30'd0, busy16, busy8}, 32'h3);
        errAt = 0;
        for (int k = 1; k <= 40 && errAt == 0; k++) begin
            step(1'b0, 8'h00);
            if (err16 || err8) errAt = k;
        end
        checkVal("to_err_cycle", errAt, 20);
        checkVal("to_err_both", {30'd0, err16, err8}, 32'h3);
        checkVal("to_code", {28'd0, ec16, ec8}, 32'hA);
        checkVal("to_busy_low", {30'd0, busy16, busy8}, 32'h0);
        checkVal("to_no_done", {30'd0, done16, done8}, 32'h0);
        step(1'b0, 8'h00);
        checkVal("to_err_single", {30'd0, err16, err8}, 32'h0);
        checkVal("to_code_held", {28'd0, ec16, ec8}, 32'hA);

        // ---------------- byte on the expiry cycle wins ----------------
        step(1'b1, 8'hA5);
        step(1'b1, 8'h12);
        sawErr = 1'b0;
        for (int k = 0; k < 19; k++) begin
            step(1'b0, 8'h00);
            sawErr = sawErr | err16 | err8;
        end
        step(1'b1, 8'h34);
        sawErr = sawErr | err16 | err8;
        checkVal("edge_no_err", {31'd0, sawErr}, 32'h0);
        checkVal("edge_busy", {30'd0, busy16, busy8}, 32'h3);
        step(1'b1, 8'h00);
        step(1'b1, 8'h01);
        step(1'b1, 8'hAA);
        checkVal("edge_we", {30'd0, we16, we8}, 32'h3);
        checkVal("edge_addr16", {16'd0, addr16}, 32'h1234);
        checkVal("edge_addr8", {24'd0, addr8}, 32'h34);
        checkVal("edge_wdata", {16'd0, wd16, wd8}, 32'hAAAA);
        step(1'b1, 8'hAA);
        checkVal("edge_done", {28'd0, done16, done8, err16, err8}, 32'hC);
        step(1'b0, 8'h00);
        checkVal("edge_idle", {28'd0, busy16, busy8, done16, done8}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
